dds_tune_ctrl: RTL and testbench

Operator-facing tuning controller for the DDS. It takes three raw asynchronous push-buttons (up, down, step-size), synchronises and debounces them, and generates press and auto-repeat events. It maintains the DDS phase increment register with saturating arithmetic and delivers each new value to the DDS core over a valid/ready configuration handshake. It sits between the board button pins and the DDS phase accumulator's configuration input.

---
 rtl/dds_tune_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 87 ++++++++
 rtl/dds_tune_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dds_tune_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dds_tune_pkg.sv
// Shared types and constants for the DDS tuning controller.
// FSM states, step-index type, step table and tuning direction.
package dds_tune_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } state_t;

    typedef logic [1:0] step_idx_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

    localparam logic [31:0] STEP_TABLE [4] = '{
        32'd1,
        32'd256,
        32'd65536,
        32'd16777216
    };

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce, press pulse and
// optional auto-repeat pulse.
// Ports: clk, rst (sync, active-high), raw (async pin), hold_clr (holds
// repeat counter at 0), level (debounced), press (1-cycle rising-edge
// pulse), rpt (1-cycle auto-repeat pulse, only when REPEAT_EN).
module btn_debounce #(
    parameter int DEBOUNCE_CYC   = 500000,
    parameter bit REPEAT_EN      = 1'b0,
    parameter int REPEAT_DLY_CYC = 25000000,
    parameter int REPEAT_CYC     = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic hold_clr,
    output logic level,
    output logic press,
    output logic rpt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]      sync;
    logic [DB_W-1:0] db_cnt;

    // Any disagreement between the synchronised input and the debounced
    // level is counted; returning to agreement (a bounce) restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                level  <= sync[1];
                press  <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_rpt
            localparam int RP_W = $clog2(REPEAT_DLY_CYC + REPEAT_CYC + 1);

            logic [RP_W-1:0] rp_cnt;
            logic [RP_W-1:0] rp_lim;
            logic            rp_run;

            // First repeat after the long delay, then the short period.
            assign rp_lim = rp_run ? RP_W'(REPEAT_CYC - 1)
                                   : RP_W'(REPEAT_DLY_CYC - 1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rp_cnt <= '0;
                    rp_run <= 1'b0;
                    rpt    <= 1'b0;
                end else begin
                    rpt <= 1'b0;
                    if (!level || hold_clr) begin
                        rp_cnt <= '0;
                        rp_run <= 1'b0;
                    end else if (rp_cnt == rp_lim) begin
                        rp_cnt <= '0;
                        rp_run <= 1'b1;
                        rpt    <= 1'b1;
                    end else begin
                        rp_cnt <= rp_cnt + RP_W'(1);
                    end
                end
            end
        end else begin : g_norpt
            logic unused_hold;
            assign unused_hold = hold_clr;
            assign rpt         = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/dds_tune_ctrl.sv
// DDS tuning controller: conditions up/down/step buttons, keeps the phase
// increment with clamped arithmetic and pushes each new value over a
// valid/ready handshake. Define DDS_TUNE_WRAP_EN to wrap at the limits
// (over MAX -> MIN, under MIN -> MAX) instead of saturating.
// Ports: clk, rst (sync, active-high), i_btn_up/i_btn_dn/i_btn_step (raw
// buttons), o_pinc/o_pinc_valid/i_pinc_ready (config handshake),
// o_step_idx (step table index), o_busy (event accepted, not yet sent).
module dds_tune_ctrl
    import dds_tune_pkg::*;
#(
    parameter int                PINC_W         = 32,
    parameter int                DEBOUNCE_CYC   = 500000,
    parameter int                REPEAT_DLY_CYC = 25000000,
    parameter int                REPEAT_CYC     = 5000000,
    parameter logic [PINC_W-1:0] PINC_MIN       = 86,
    parameter logic [PINC_W-1:0] PINC_MAX       = 'h4000_0000,
    parameter logic [PINC_W-1:0] PINC_RST       = 'h0147_AE14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_btn_up,
    input  logic              i_btn_dn,
    input  logic              i_btn_step,
    output logic [PINC_W-1:0] o_pinc,
    output logic              o_pinc_valid,
    input  logic              i_pinc_ready,
    output logic [1:0]        o_step_idx,
    output logic              o_busy
);

`ifdef DDS_TUNE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic up_lvl, up_press, up_rpt;
    logic dn_lvl, dn_press, dn_rpt;
    logic st_lvl, st_press, st_rpt;
    logic both, lock, hold_clr;
    logic ev_up, ev_dn, ev;
    dir_t ev_dir;

    state_t    state;
    dir_t      dir;
    dir_t      pend_dir;
    logic      pend_v;
    step_idx_t step_idx;

    logic [PINC_W:0]   step_ext;
    logic [PINC_W:0]   sum;
    logic [PINC_W-1:0] cand;

    btn_debounce #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_EN     (1'b1),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .raw     (i_btn_up),
        .hold_clr(hold_clr),
        .level   (up_lvl),
        .press   (up_press),
        .rpt     (up_rpt)
    );

    btn_debounce #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_EN     (1'b1),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_dn (
        .clk     (clk),
        .rst     (rst),
        .raw     (i_btn_dn),
        .hold_clr(hold_clr),
        .level   (dn_lvl),
        .press   (dn_press),
        .rpt     (dn_rpt)
    );

    btn_debounce #(
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_EN     (1'b0),
        .REPEAT_DLY_CYC(REPEAT_DLY_CYC),
        .REPEAT_CYC    (REPEAT_CYC)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .raw     (i_btn_step),
        .hold_clr(1'b0),
        .level   (st_lvl),
        .press   (st_press),
        .rpt     (st_rpt)
    );

    logic unused_st;
    assign unused_st = st_lvl ^ st_rpt;

    // Holding both buttons locks out repeats until a fresh single press;
    // the unlocking press must not lose its first repeat-counter cycle.
    assign both     = up_lvl & dn_lvl;
    assign hold_clr = both | (lock & ~(up_press | dn_press));
    assign ev_up    = ~both & (up_press | up_rpt);
    assign ev_dn    = ~both & (dn_press | dn_rpt);
    assign ev       = ev_up | ev_dn;
    assign ev_dir   = ev_dn ? DIR_DN : DIR_UP;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock <= 1'b0;
        end else if (both) begin
            lock <= 1'b1;
        end else if (up_press | dn_press) begin
            lock <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_idx <= '0;
        end else if (st_press) begin
            step_idx <= step_idx + 2'd1;
        end
    end

    assign o_step_idx = step_idx;
    assign step_ext   = (PINC_W + 1)'(STEP_TABLE[step_idx]);

    // Extra MSB catches carry on up and borrow on down.
    always_comb begin
        sum  = '0;
        cand = o_pinc;
        if (dir == DIR_UP) begin
            sum = {1'b0, o_pinc} + step_ext;
            if (sum > {1'b0, PINC_MAX}) begin
                cand = WRAP ? PINC_MIN : PINC_MAX;
            end else begin
                cand = sum[PINC_W-1:0];
            end
        end else begin
            sum = {1'b0, o_pinc} - step_ext;
            if (sum[PINC_W] || (sum < {1'b0, PINC_MIN})) begin
                cand = WRAP ? PINC_MAX : PINC_MIN;
            end else begin
                cand = sum[PINC_W-1:0];
            end
        end
    end

    // Reset parks in SEND with valid low so the first cycle out of reset
    // raises valid for the initial PINC_RST push.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEND;
            o_pinc       <= PINC_RST;
            o_pinc_valid <= 1'b0;
            o_busy       <= 1'b1;
            dir          <= DIR_UP;
            pend_v       <= 1'b0;
            pend_dir     <= DIR_UP;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_v) begin
                        dir      <= pend_dir;
                        pend_v   <= ev;
                        pend_dir <= ev_dir;
                        o_busy   <= 1'b1;
                        state    <= CALC;
                    end else if (ev) begin
                        dir    <= ev_dir;
                        o_busy <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (cand == o_pinc) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        o_pinc       <= cand;
                        o_pinc_valid <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (o_pinc_valid && i_pinc_ready) begin
                        o_pinc_valid <= 1'b0;
                        o_busy       <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        o_pinc_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && ev && !pend_v) begin
                pend_v   <= 1'b1;
                pend_dir <= ev_dir;
            end
        end
    end

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Directed bench for dds_tune_ctrl with shortened debounce/repeat times.
// Transfers are logged with their cycle number and checked step by step.
module tb_dds_tune_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_dn = 1'b0;
    logic        btn_step = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] pinc;
    logic        valid;
    logic [1:0]  step_idx;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] xv[$];
    int          xt[$];

    dds_tune_ctrl #(
        .PINC_W        (32),
        .DEBOUNCE_CYC  (4),
        .REPEAT_DLY_CYC(20),
        .REPEAT_CYC    (5),
        .PINC_MIN      (32'd10),
        .PINC_MAX      (32'd1100),
        .PINC_RST      (32'd1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_up    (btn_up),
        .i_btn_dn    (btn_dn),
        .i_btn_step  (btn_step),
        .o_pinc      (pinc),
        .o_pinc_valid(valid),
        .i_pinc_ready(ready),
        .o_step_idx  (step_idx),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && valid && ready) begin
            xv.push_back(pinc);
            xt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] xval(input int i);
        if (i >= 0 && i < xv.size()) return xv[i];
        return 'x;
    endfunction

    function automatic int xtime(input int i);
        if (i >= 0 && i < xt.size()) return xt[i];
        return -1000;
    endfunction

    initial begin
        int b;
        int bad;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_pinc", pinc, 32'd1000);
        check("rst_step", {30'd0, step_idx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);

        // 1: initial push after reset
        step(1);
        rst   = 1'b0;
        ready = 1'b1;
        step(6);
        @(negedge clk);
        check("init_count", xv.size(), 32'd1);
        check("init_val", xval(0), 32'd1000);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_valid", {31'd0, valid}, 32'd0);

        // 2: bounces alone do nothing, a clean hold gives one step
        step(1);
        b = xv.size();
        btn_up = 1'b1; step(1);
        btn_up = 1'b0; step(1);
        btn_up = 1'b1; step(1);
        btn_up = 1'b0;
        step(12);
        check("bounce_none", xv.size(), b);
        btn_up = 1'b1; step(6);
        btn_up = 1'b0;
        step(12);
        check("up_count", xv.size(), b + 1);
        check("up_val", xval(b), 32'd1001);

        // 3: step to 256, up clamps at MAX, second up at the limit
        b = xv.size();
        btn_step = 1'b1; step(6);
        btn_step = 1'b0;
        step(12);
        check("step_idx", {30'd0, step_idx}, 32'd1);
        check("step_no_xfer", xv.size(), b);
        btn_up = 1'b1; step(6);
        btn_up = 1'b0;
        step(12);
        check("clamp_count", xv.size(), b + 1);
        check("clamp_val", xval(b), 32'd1100);
        btn_up = 1'b1; step(6);
        btn_up = 1'b0;
        step(12);
`ifdef DDS_TUNE_WRAP_EN
        check("limit_count", xv.size(), b + 2);
        check("wrap_val", xval(b + 1), 32'd10);
`else
        check("limit_count", xv.size(), b + 1);
        check("limit_pinc", pinc, 32'd1100);
`endif
        check("limit_busy", {31'd0, busy}, 32'd0);

        // 4: reset, then hold dn long enough for two repeats
        b = xv.size();
        rst = 1'b1; step(2);
        rst = 1'b0; step(6);
        check("rst2_count", xv.size(), b + 1);
        check("rst2_val", xval(b), 32'd1000);
        b = xv.size();
        btn_dn = 1'b1; step(28);
        btn_dn = 1'b0;
        step(15);
        check("rpt_count", xv.size(), b + 3);
        check("rpt_v0", xval(b), 32'd999);
        check("rpt_v1", xval(b + 1), 32'd998);
        check("rpt_v2", xval(b + 2), 32'd997);
        check("rpt_dly", xtime(b + 1) - xtime(b), 32'd20);
        check("rpt_per", xtime(b + 2) - xtime(b + 1), 32'd5);

        // 5: ready low while three up events arrive; one is dropped
        b = xv.size();
        ready  = 1'b0;
        bad    = 0;
        btn_up = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (i >= 12 && !(valid === 1'b1 && pinc === 32'd998)) bad++;
            @(posedge clk);
            #1;
            if (i == 27) btn_up = 1'b0;
        end
        check("hold_stable", bad, 32'd0);
        check("hold_no_xfer", xv.size(), b);
        ready = 1'b1;
        step(12);
        check("drop_count", xv.size(), b + 2);
        check("drop_v0", xval(b), 32'd998);
        check("drop_v1", xval(b + 1), 32'd999);

        // 6: both held gives nothing; reset in the middle of SEND
        b = xv.size();
        btn_up = 1'b1;
        btn_dn = 1'b1;
        step(50);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        step(12);
        check("both_none", xv.size(), b);
        check("both_pinc", pinc, 32'd999);
        check("both_busy", {31'd0, busy}, 32'd0);
        ready  = 1'b0;
        btn_up = 1'b1; step(6);
        btn_up = 1'b0;
        step(10);
        @(negedge clk);
        check("send_valid", {31'd0, valid}, 32'd1);
        check("send_pinc", pinc, 32'd1000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", {31'd0, valid}, 32'd1);
        @(negedge clk);
        check("rst_valid_lo", {31'd0, valid}, 32'd0);
        check("rst_busy_hi", {31'd0, busy}, 32'd1);
        step(1);
        rst   = 1'b0;
        ready = 1'b1;
        step(6);
        check("rst3_count", xv.size(), b + 1);
        check("rst3_val", xval(b), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
